// File: rtl/ocp_pkg.sv
// Shared OCP encodings plus the master request bridge state type.
//   ocp_cmd_t        : MCmd-style command encodings driven on s_cmd
//   ocp_resp_t       : SResp-style response encodings sampled on s_resp
//   m_bridge_state_t : master request bridge FSM states
package ocp_pkg;

  localparam int unsigned OCP_CMD_W  = 3;
  localparam int unsigned OCP_RESP_W = 2;

  typedef enum logic [OCP_CMD_W-1:0] {
    S_CMD_IDLE = 3'b000,
    S_CMD_WR   = 3'b001,
    S_CMD_RD   = 3'b010
  } ocp_cmd_t;

  typedef enum logic [OCP_RESP_W-1:0] {
    S_RESP_NULL = 2'b00,
    S_RESP_DVA  = 2'b01,
    S_RESP_ERR  = 2'b11
  } ocp_resp_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CMD       = 2'd1,
    WAIT_RESP = 2'd2
  } m_bridge_state_t;

  // Command encoding for a client request direction.
  function automatic ocp_cmd_t cmd_for(input logic is_write);
    return is_write ? S_CMD_WR : S_CMD_RD;
  endfunction

endpackage

// File: rtl/ocp_if.sv
// Single-word OCP command/response bus between a master and a slave bridge.
//   master drives : s_cmd, m_addr, m_data, m_resp_accept
//   slave drives  : s_cmd_accept, s_resp, s_data
interface ocp_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  import ocp_pkg::*;

  ocp_cmd_t                s_cmd;
  logic [ADDR_WIDTH-1:0]   m_addr;
  logic [DATA_WIDTH-1:0]   m_data;
  logic                    m_resp_accept;
  logic                    s_cmd_accept;
  ocp_resp_t               s_resp;
  logic [DATA_WIDTH-1:0]   s_data;

  modport master (
    output s_cmd, m_addr, m_data, m_resp_accept,
    input  s_cmd_accept, s_resp, s_data
  );

  modport slave (
    input  s_cmd, m_addr, m_data, m_resp_accept,
    output s_cmd_accept, s_resp, s_data
  );

endinterface

// File: rtl/ocp_master_request_bridge.sv
// Local request/response port to OCP master bridge. Accepts one single-word
// read or write at a time, runs the OCP command phase, waits for the slave
// response and returns read data and error status. A response timeout guards
// against a dead slave; late responses arriving in IDLE are drained.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   enable       : global enable, block frozen when low
//   m_ocp        : OCP master side (command out, response in)
//   req_*        : client request (valid/ready handshake)
//   rsp_*        : client response, rsp_valid is a one-cycle pulse
//   busy         : transaction in flight
module ocp_master_request_bridge
  import ocp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  ocp_if.master                 m_ocp,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  rsp_timeout,
  output logic                  busy
);

  localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);
  localparam int unsigned CNT_W = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Expiry fires on the edge where the counter would reach TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  m_bridge_state_t  state;
  logic [CNT_W-1:0] tmo_cnt;
  logic             resp_seen;
  logic             timeout_hit;

  assign resp_seen   = (m_ocp.s_resp != S_RESP_NULL);
  assign timeout_hit = TO_EN && (tmo_cnt == TO_LAST);
  assign busy        = (state != IDLE);

  // IDLE with a pending response is a stale drain: accept it, block new work.
  assign req_ready = enable && !reset && (state == IDLE) && !resp_seen;
  assign m_ocp.m_resp_accept = enable && !reset && resp_seen &&
                               ((state == WAIT_RESP) || (state == IDLE));

  // Bridge FSM with registered bus and response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      tmo_cnt      <= '0;
      m_ocp.s_cmd  <= S_CMD_IDLE;
      m_ocp.m_addr <= '0;
      m_ocp.m_data <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_error    <= 1'b0;
      rsp_timeout  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (enable) begin
        case (state)
          IDLE: begin
            if (req_valid && req_ready) begin
              m_ocp.s_cmd  <= cmd_for(req_write);
              m_ocp.m_addr <= req_addr;
              if (req_write) m_ocp.m_data <= req_wdata;
              tmo_cnt      <= '0;
              state        <= CMD;
            end
          end

          CMD: begin
            if (TO_EN) tmo_cnt <= tmo_cnt + CNT_W'(1);
            if (timeout_hit) begin
              m_ocp.s_cmd <= S_CMD_IDLE;
              rsp_valid   <= 1'b1;
              rsp_error   <= 1'b1;
              rsp_timeout <= 1'b1;
              state       <= IDLE;
            end else if (m_ocp.s_cmd_accept) begin
              m_ocp.s_cmd <= S_CMD_IDLE;
              state       <= WAIT_RESP;
            end
          end

          WAIT_RESP: begin
            if (TO_EN) tmo_cnt <= tmo_cnt + CNT_W'(1);
            // A response on the expiry edge takes priority over the timeout.
            if (m_ocp.m_resp_accept) begin
              rsp_rdata   <= m_ocp.s_data;
              rsp_error   <= (m_ocp.s_resp == S_RESP_ERR);
              rsp_timeout <= 1'b0;
              rsp_valid   <= 1'b1;
              state       <= IDLE;
            end else if (timeout_hit) begin
              m_ocp.s_cmd <= S_CMD_IDLE;
              rsp_valid   <= 1'b1;
              rsp_error   <= 1'b1;
              rsp_timeout <= 1'b1;
              state       <= IDLE;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ocp_master_request_bridge.sv
// Directed self-checking bench for ocp_master_request_bridge (TIMEOUT_CYCLES=8).
module tb_ocp_master_request_bridge;
  import ocp_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          req_valid;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_error;
  logic          rsp_timeout;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  ocp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ocp_master_request_bridge #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .m_ocp(bus),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; stimulus and sampling happen 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request, confirm acceptance, and leave the bridge in CMD.
  task automatic handshake(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    #1;
    check("hs_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check("hs_busy", 32'(busy), 32'd1);
    check("hs_cmd", 32'(bus.s_cmd), wr ? 32'(S_CMD_WR) : 32'(S_CMD_RD));
    check("hs_addr", 32'(bus.m_addr), 32'(a));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    bus.s_cmd_accept = 1'b0; bus.s_resp = S_RESP_NULL; bus.s_data = '0;

    // Reset state
    tick(); tick();
    check("rst_cmd", 32'(bus.s_cmd), 32'(S_CMD_IDLE));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_addr", 32'(bus.m_addr), 32'd0);
    check("rst_data", bus.m_data, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_ready_in_reset", 32'(req_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("rst_ready_after", 32'(req_ready), 32'd1);

    // Write 0x0A <- DEADBEEF, accept one cycle after command, DVA 3 cycles later
    handshake(1'b1, 5'h0A, 32'hDEADBEEF);
    check("wr_data", bus.m_data, 32'hDEADBEEF);
    check("wr_ready_busy", 32'(req_ready), 32'd0);
    tick();
    check("wr_cmd_hold", 32'(bus.s_cmd), 32'(S_CMD_WR));
    bus.s_cmd_accept = 1'b1;
    tick();
    bus.s_cmd_accept = 1'b0;
    check("wr_cmd_idle", 32'(bus.s_cmd), 32'(S_CMD_IDLE));
    check("wr_wait_acc", 32'(bus.m_resp_accept), 32'd0);
    tick(); tick();
    bus.s_resp = S_RESP_DVA;
    #1;
    check("wr_resp_acc", 32'(bus.m_resp_accept), 32'd1);
    tick();
    bus.s_resp = S_RESP_NULL;
    check("wr_valid", 32'(rsp_valid), 32'd1);
    check("wr_error", 32'(rsp_error), 32'd0);
    check("wr_busy_done", 32'(busy), 32'd0);
    tick();
    check("wr_valid_end", 32'(rsp_valid), 32'd0);

    // Read 0x03, zero-wait slave returns 12345678 with DVA
    handshake(1'b0, 5'h03, 32'h0);
    check("rd_data_kept", bus.m_data, 32'hDEADBEEF);
    bus.s_cmd_accept = 1'b1;
    tick();
    bus.s_cmd_accept = 1'b0;
    check("rd_cmd_idle", 32'(bus.s_cmd), 32'(S_CMD_IDLE));
    bus.s_resp = S_RESP_DVA; bus.s_data = 32'h12345678;
    #1;
    check("rd_acc_on", 32'(bus.m_resp_accept), 32'd1);
    tick();
    bus.s_resp = S_RESP_NULL;
    #1;
    check("rd_acc_off", 32'(bus.m_resp_accept), 32'd0);
    check("rd_valid", 32'(rsp_valid), 32'd1);
    check("rd_rdata", rsp_rdata, 32'h12345678);
    check("rd_error", 32'(rsp_error), 32'd0);
    tick();

    // Read answered with ERR
    handshake(1'b0, 5'h04, 32'h0);
    bus.s_cmd_accept = 1'b1;
    tick();
    bus.s_cmd_accept = 1'b0;
    bus.s_resp = S_RESP_ERR; bus.s_data = 32'hCAFE0001;
    tick();
    bus.s_resp = S_RESP_NULL;
    check("err_valid", 32'(rsp_valid), 32'd1);
    check("err_error", 32'(rsp_error), 32'd1);
    check("err_timeout", 32'(rsp_timeout), 32'd0);
    tick();

    // Slave never accepts: timeout 8 cycles after CMD entry
    handshake(1'b0, 5'h11, 32'h0);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("to_busy", 32'(busy), 32'd1);
      check("to_no_valid", 32'(rsp_valid), 32'd0);
    end
    tick();
    check("to_valid", 32'(rsp_valid), 32'd1);
    check("to_error", 32'(rsp_error), 32'd1);
    check("to_flag", 32'(rsp_timeout), 32'd1);
    check("to_cmd_idle", 32'(bus.s_cmd), 32'(S_CMD_IDLE));
    check("to_busy_done", 32'(busy), 32'd0);
    check("to_rdata_kept", rsp_rdata, 32'hCAFE0001);

    // Late DVA drained in IDLE; pending request not accepted meanwhile
    bus.s_resp = S_RESP_DVA; bus.s_data = 32'hFFFF0000;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'h01;
    #1;
    check("drain_acc", 32'(bus.m_resp_accept), 32'd1);
    check("drain_ready", 32'(req_ready), 32'd0);
    tick();
    bus.s_resp = S_RESP_NULL; req_valid = 1'b0;
    check("drain_no_valid", 32'(rsp_valid), 32'd0);
    check("drain_busy", 32'(busy), 32'd0);
    check("drain_rdata", rsp_rdata, 32'hCAFE0001);
    tick();
    check("drain_no_valid2", 32'(rsp_valid), 32'd0);

    // Response on the expiry edge wins over the timeout
    handshake(1'b0, 5'h12, 32'h0);
    bus.s_cmd_accept = 1'b1;
    tick();
    bus.s_cmd_accept = 1'b0;
    repeat (6) tick();
    bus.s_resp = S_RESP_DVA; bus.s_data = 32'h55AA55AA;
    tick();
    bus.s_resp = S_RESP_NULL;
    check("sim_valid", 32'(rsp_valid), 32'd1);
    check("sim_error", 32'(rsp_error), 32'd0);
    check("sim_timeout", 32'(rsp_timeout), 32'd0);
    check("sim_rdata", rsp_rdata, 32'h55AA55AA);
    tick();

    // enable low for 5 cycles in WAIT_RESP with DVA pending, one cycle from expiry
    handshake(1'b0, 5'h07, 32'h0);
    bus.s_cmd_accept = 1'b1;
    tick();
    bus.s_cmd_accept = 1'b0;
    repeat (5) tick();
    enable = 1'b0;
    bus.s_resp = S_RESP_DVA; bus.s_data = 32'h600DF00D;
    #1;
    check("en_ready_low", 32'(req_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      check("en_no_acc", 32'(bus.m_resp_accept), 32'd0);
      tick();
      check("en_busy", 32'(busy), 32'd1);
      check("en_no_valid", 32'(rsp_valid), 32'd0);
    end
    enable = 1'b1;
    #1;
    check("en_acc", 32'(bus.m_resp_accept), 32'd1);
    tick();
    bus.s_resp = S_RESP_NULL;
    enable = 1'b0;
    check("en_valid", 32'(rsp_valid), 32'd1);
    check("en_timeout", 32'(rsp_timeout), 32'd0);
    check("en_rdata", rsp_rdata, 32'h600DF00D);
    tick();
    check("en_valid_single", 32'(rsp_valid), 32'd0);
    enable = 1'b1;
    tick();

    // Reset during CMD
    handshake(1'b1, 5'h1F, 32'h0BADC0DE);
    reset = 1'b1;
    tick();
    check("rmid_cmd", 32'(bus.s_cmd), 32'(S_CMD_IDLE));
    check("rmid_busy", 32'(busy), 32'd0);
    check("rmid_addr", 32'(bus.m_addr), 32'd0);
    check("rmid_ready_in_reset", 32'(req_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("rmid_ready", 32'(req_ready), 32'd1);
    tick();
    check("rmid_no_valid", 32'(rsp_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ocp_master_request_bridge.md
Name: ocp_master_request_bridge

Overview:
Local request/response port to OCP master bridge. It is the initiator for the team's existing OCP slave-side memory bridges. It accepts one single-word read or write from a local client such as a CPU stub or test driver, drives the OCP command phase, and waits for the slave's response. It then returns read data and error status to the client. One transaction is in flight at a time, and a response timeout protects against a dead slave.

Parameters:
DATA_WIDTH, 32, width of m_data, s_data, req_wdata and rsp_rdata.
ADDR_WIDTH, 5, width of m_addr and req_addr.
TIMEOUT_CYCLES, 64, cycles allowed in the CMD and WAIT_RESP states combined; 0 disables the timeout.

Ports:
clk  input  1  clock.
reset  input  1  synchronous, active-high reset.
enable  input  1  global enable; when low the block is frozen.
m_ocp  ocp_if.master  -  drives s_cmd, m_addr, m_data, m_resp_accept; samples s_cmd_accept, s_resp, s_data.
req_valid  input  1  client request present.
req_write  input  1  1 = write, 0 = read.
req_addr  input  ADDR_WIDTH  request address.
req_wdata  input  DATA_WIDTH  write data.
req_ready  output  1  combinational: enable && state==IDLE && !reset.
rsp_valid  output  1  one-cycle pulse when the transaction completes.
rsp_rdata  output  DATA_WIDTH  captured s_data; valid with rsp_valid on a successful read.
rsp_error  output  1  slave returned S_RESP_ERR, or the timeout expired; valid with rsp_valid.
rsp_timeout  output  1  timeout cause; valid with rsp_valid.
busy  output  1  state != IDLE.

Behaviour:
- Reset values:
  - state IDLE; s_cmd = S_CMD_IDLE.
  - m_addr, m_data, rsp_rdata = 0.
  - rsp_valid, rsp_error, rsp_timeout = 0; timeout counter = 0.
- FSM state IDLE:
  - On req_valid && req_ready, register s_cmd (S_CMD_WR or S_CMD_RD), m_addr and m_data (m_data is loaded on writes only) and go to CMD.
  - Command appears on the bus the cycle after the handshake.
- FSM state CMD:
  - Hold s_cmd, m_addr and m_data stable until s_cmd_accept is sampled high.
  - On that edge, drive s_cmd to S_CMD_IDLE and go to WAIT_RESP.
  - The slave registers s_cmd_accept one cycle after seeing the command, so the minimum CMD residency is 2 cycles.
- FSM state WAIT_RESP:
  - m_resp_accept is combinational: (state==WAIT_RESP) && enable && s_resp != S_RESP_NULL.
  - On that cycle's edge:
    - capture s_data into rsp_rdata;
    - set rsp_error = (s_resp==S_RESP_ERR) and rsp_timeout = 0;
    - pulse rsp_valid next cycle and return to IDLE.
- Timeout:
  - The counter clears on entry to CMD and increments each enabled cycle in CMD or WAIT_RESP.
  - When it reaches TIMEOUT_CYCLES:
    - s_cmd goes to IDLE;
    - rsp_valid pulses with rsp_error=1, rsp_timeout=1 and rsp_rdata unchanged;
    - state returns to IDLE.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Stale response drain: in IDLE, if s_resp != S_RESP_NULL (a late response after a timeout), assert m_resp_accept, discard the data and hold req_ready low for that cycle.
- Simultaneous events: if a response arrives on the same edge the timeout expires, the response wins and rsp_timeout = 0.
- enable low:
  - state, counter and all registered outputs hold; m_resp_accept = 0 and req_ready = 0.
  - rsp_valid still deasserts after its single cycle, so no repeated pulse is generated.
- reset mid-transaction: returns to the reset values at the next edge. Any slave response left pending afterwards is removed by the stale-response drain.
- Latency, read with a zero-wait slave: handshake at cycle 0, s_cmd at cycle 1, s_cmd_accept at cycle 2, s_cmd idle at cycle 3. rsp_valid follows one cycle after the s_resp/m_resp_accept cycle.

Decomposition:
- ocp_pkg already holds S_CMD_IDLE/RD/WR and S_RESP_NULL/DVA/ERR.
- Add to ocp_pkg: the state enum m_bridge_state_t (IDLE, CMD, WAIT_RESP).
- Single module; the timeout counter is inline and needs no sub-module.

Test Plan:
- Write addr 5'h0A, data 32'hDEADBEEF, slave answers DVA after 3 cycles -> s_cmd=WR held until s_cmd_accept; rsp_valid=1 for 1 cycle; rsp_error=0; busy low afterwards.
- Read addr 5'h03, slave returns s_data=32'h12345678 with DVA -> rsp_rdata=32'h12345678; m_resp_accept high exactly 1 cycle.
- Read, slave returns S_RESP_ERR -> rsp_valid with rsp_error=1, rsp_timeout=0.
- TIMEOUT_CYCLES=8, slave never responds -> rsp_valid 8 cycles after CMD entry with rsp_error=1, rsp_timeout=1. A DVA injected later is drained in IDLE and produces no rsp_valid.
- enable dropped for 5 cycles during WAIT_RESP while s_resp=DVA -> no m_resp_accept, no timeout progress; completes on re-enable.
- reset asserted during CMD -> next cycle s_cmd=S_CMD_IDLE, busy=0, req_ready=1 once reset is released.
